// File: rtl/vga_rect_painter.sv
// Bus-initiator that fills an axis-aligned rectangle of the 160x120 frame buffer
// by issuing X/Y/pixel register writes to the VGA peripheral under request/grant arbitration.
module vga_rect_painter #(
  parameter logic [7:0]  VGABaseAddress = 8'hB0,
  parameter int unsigned X_MAX          = 159,
  parameter int unsigned Y_MAX          = 119
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [7:0]      X0,
  input  logic [7:0]      X1,
  input  logic [6:0]      Y0,
  input  logic [6:0]      Y1,
  input  logic            COLOUR,
  output logic            BUS_REQ,
  input  logic            BUS_GNT,
  output logic [7:0]      BUS_ADDR,
  inout  wire logic [7:0] BUS_DATA,
  output logic            BUS_WE,
  output logic            BUSY,
  output logic            DONE
);

  typedef enum logic [2:0] {IDLE, REQ, WR_Y, WR_X, WR_P, FIN} state_t;

  state_t     state, ns;
  logic [7:0] x, xl, xh, nx;
  logic [6:0] y, yl, yh, ny;
  logic       colour_q;
  logic       drive;
  logic [7:0] addr_q, data_q, n_addr, n_data;

  logic [7:0] x0s, x1s;
  logic [6:0] y0s, y1s;

  // Saturate each corner first so min/max and the counters stay inside the frame.
  always_comb begin
    x0s = (X0 > 8'(X_MAX)) ? 8'(X_MAX) : X0;
    x1s = (X1 > 8'(X_MAX)) ? 8'(X_MAX) : X1;
    y0s = (Y0 > 7'(Y_MAX)) ? 7'(Y_MAX) : Y0;
    y1s = (Y1 > 7'(Y_MAX)) ? 7'(Y_MAX) : Y1;
  end

  // drive=1 means the write for the current state is on the bus this cycle;
  // the state only advances once that write has actually been issued.
  always_comb begin
    ns = state;
    nx = x;
    ny = y;
    unique case (state)
      WR_Y: if (drive) ns = WR_X;
      WR_X: if (drive) ns = WR_P;
      WR_P: if (drive) begin
        if (x < xh) begin
          nx = x + 8'd1;
          ns = WR_X;
        end else if (y < yh) begin
          nx = xl;
          ny = y + 7'd1;
          ns = WR_Y;
        end else begin
          ns = FIN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    n_addr = VGABaseAddress + 8'd2;
    n_data = {7'b0, colour_q};
    unique case (ns)
      WR_Y: begin
        n_addr = VGABaseAddress + 8'd1;
        n_data = {1'b0, ny};
      end
      WR_X: begin
        n_addr = VGABaseAddress;
        n_data = nx;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      x        <= '0;
      y        <= '0;
      xl       <= '0;
      xh       <= '0;
      yl       <= '0;
      yh       <= '0;
      colour_q <= 1'b0;
      drive    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      BUS_REQ  <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        IDLE: if (START) begin
          xl       <= (x0s < x1s) ? x0s : x1s;
          xh       <= (x0s < x1s) ? x1s : x0s;
          yl       <= (y0s < y1s) ? y0s : y1s;
          yh       <= (y0s < y1s) ? y1s : y0s;
          x        <= (x0s < x1s) ? x0s : x1s;
          y        <= (y0s < y1s) ? y0s : y1s;
          colour_q <= COLOUR;
          BUSY     <= 1'b1;
          BUS_REQ  <= 1'b1;
          state    <= REQ;
        end
        REQ: if (BUS_GNT) begin
          state  <= WR_Y;
          drive  <= 1'b1;
          addr_q <= VGABaseAddress + 8'd1;
          data_q <= {1'b0, y};
        end
        WR_Y, WR_X, WR_P: begin
          state <= ns;
          x     <= nx;
          y     <= ny;
          if (ns == FIN) begin
            drive   <= 1'b0;
            DONE    <= 1'b1;
            BUS_REQ <= 1'b0;
          end else begin
            drive  <= BUS_GNT;
            addr_q <= n_addr;
            data_q <= n_data;
          end
        end
        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign BUS_ADDR = drive ? addr_q : 'z;
  assign BUS_DATA = drive ? data_q : 'z;
  assign BUS_WE   = drive ? 1'b1 : 1'bz;

endmodule

// File: doc/vga_rect_painter.md
# vga_rect_painter

Hardware bus initiator that fills an axis-aligned rectangle of the 160x120 monochrome frame buffer by issuing write transactions to the VGA peripheral's bus registers (base, base+1, base+2 = X, Y, pixel). It sits beside the processor on the shared 8-bit BUS_ADDR/BUS_DATA/BUS_WE bus and owns the bus only through a request/grant handshake with the bus arbiter. Its purpose is to offload clears and box draws from the processor.

## Interface
- VGABaseAddress, 8'hB0, VGA peripheral base address (X register; Y at +1, pixel at +2)
- X_MAX, 159, largest legal X coordinate
- Y_MAX, 119, largest legal Y coordinate

- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle request to paint; sampled only in IDLE
- X0, X1  in  8 each  corner X coordinates, any order
- Y0, Y1  in  7 each  corner Y coordinates (logical, top row = 0), any order
- COLOUR  in  1  pixel value written to every pixel of the rectangle
- BUS_REQ  out  1  bus request to arbiter
- BUS_GNT  in  1  bus grant from arbiter
- BUS_ADDR  out (tri-state)  8  driven only while owning the bus, else Z
- BUS_DATA  inout  8  driven only during a painter write cycle, else Z
- BUS_WE  out (tri-state)  1  driven only while owning the bus, else Z
- BUSY  out  1  high from accepted START until DONE
- DONE  out  1  one-cycle pulse when the last pixel write has been issued

## Operation
- START in IDLE latches xl=min(X0,X1), xh=max(X0,X1), yl=min(Y0,Y1), yh=max(Y0,Y1), and COLOUR. Each bound saturates at X_MAX or Y_MAX. START outside IDLE is ignored.
- States: IDLE, REQ, WR_Y, WR_X, WR_P, FIN.
- IDLE: waits for START. On START: BUSY=1, x=xl, y=yl, state goes to REQ.
- REQ: BUS_REQ=1. Waits for BUS_GNT=1, then goes to WR_Y.
- WR_Y: writes y to VGABaseAddress+1. Goes to WR_X.
- WR_X: writes x to VGABaseAddress. Goes to WR_P.
- WR_P: writes {7'b0,COLOUR} to VGABaseAddress+2.
  - If x<xh: x++, go to WR_X.
  - Else if y<yh: x=xl, y++, go to WR_Y.
  - Else go to FIN.
- FIN: DONE=1 for one cycle; BUS_REQ, BUSY drop; go to IDLE.
- A write cycle means, for that single cycle: BUS_WE=1, BUS_ADDR=target, BUS_DATA=value.
- BUS_REQ stays high from REQ through the last WR_P.
- Grant loss: if BUS_GNT=0 in any WR_* state, no write is issued and the bus is tri-stated. The state and counters hold, and the same write is retried on the first cycle BUS_GNT=1 again.
- The Y written is the logical row; the peripheral performs its own row inversion.
- Counters: x is 8-bit, y is 7-bit. Because bounds are saturated first, the increments never wrap.
- Asynchronous RESET at any time forces IDLE and releases the bus immediately. No DONE pulse is produced, and the partial rectangle stays in the frame buffer.

## Timing
- Reset values: BUS_REQ=0, BUSY=0, DONE=0; BUS_ADDR, BUS_DATA, BUS_WE high-Z; state IDLE.
- START at edge 0 gives BUSY=1 and BUS_REQ=1 after edge 0.
- The first write occupies the cycle after the edge at which BUS_GNT=1 is sampled in REQ.
- With uninterrupted grant: writes per rectangle = H*(1+2W), where W=xh-xl+1 and H=yh-yl+1. DONE is high in the cycle after the last WR_P.
- All bus outputs are registered; nothing combinational runs from BUS_GNT to the bus.
- In FIN and IDLE the painter never drives BUS_WE=1.
- START arriving in the same cycle as the DONE pulse is ignored.

## Test plan
- Single pixel: X0=X1=5, Y0=Y1=7, COLOUR=1, grant tied high -> write sequence (B1,07), (B0,05), (B2,01); DONE pulses once; BUSY high for 5 cycles.
- 3x2 box: X0=10, X1=12, Y0=3, Y1=4 -> 14 writes: B1=03, then B0/B2 pairs for 0A/0B/0C; B1=04, then the same pairs again. Frame buffer model shows exactly 6 set pixels.
- Swapped and out-of-range corners: X0=200, X1=150, Y0=127, Y1=118 -> xl=150, xh=159, yl=118, yh=119; 42 writes; no address beyond X=159 or Y=119.
- Grant drop: deassert BUS_GNT for 4 cycles after the 3rd write -> bus is Z and BUS_WE is not 1 during the gap; the 4th write appears unchanged after re-grant; total write count is unchanged.
- RESET asserted mid-row (during WR_X) -> outputs reach reset values without waiting for a clock edge; no DONE; next START paints normally.
- START pulsed while BUSY=1 with different coordinates -> ignored; the original rectangle completes unaltered.
